// File: rtl/ltl_nfa_monitor_prog_pkg.sv
// Shared types for the programmable LTL NFA monitor.
// Holds the config-target enum, the interval/attribute record layouts and a width helper.
// No ports; imported by the interface, the STE matcher and the top.
package ltl_mon_pkg;

  // Config write target selected by cfg_sel.
  typedef enum logic [1:0] {
    CFG_INTV = 2'd0,
    CFG_EDGE = 2'd1,
    CFG_ATTR = 2'd2,
    CFG_CLR  = 2'd3
  } cfg_sel_e;

  localparam int SYM_W_DEF = 8;

  // Layout of an interval payload on cfg_data (MSB first): {valid, hi, lo}.
  typedef struct packed {
    logic                 valid;
    logic [SYM_W_DEF-1:0] hi;
    logic [SYM_W_DEF-1:0] lo;
  } intv_t;

  // Per-STE attributes, carried in cfg_data[2:0].
  typedef struct packed {
    logic report_en;
    logic start_all;
    logic start_sod;
  } ste_attr_t;

  // cfg_data must hold either an interval payload or a full predecessor mask.
  function automatic int cfg_w(input int sym_w, input int n_ste);
    return (n_ste > 2 * sym_w + 1) ? n_ste : 2 * sym_w + 1;
  endfunction

endpackage

// File: rtl/ltl_nfa_monitor_prog_if.sv
// Trace/config/report bundle of the programmable LTL NFA monitor.
// master: drives run, symbols and the cfg_* write port; reads the report side.
// slave:  the monitor; reads trace and config, drives cfg_err, report and counters.
interface ltl_nfa_monitor_prog_if
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int N_STE  = 16,
  parameter int N_INTV = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N_STE * N_INTV),
  parameter int CFG_W  = cfg_w(SYM_W, N_STE)
);
  logic              run;
  logic [SYM_W-1:0]  symbols;
  logic              cfg_we;
  cfg_sel_e          cfg_sel;
  logic [IDX_W-1:0]  cfg_idx;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_err;
  logic [N_STE-1:0]  report;
  logic              any_report;
  logic              report_sticky;
  logic [CNT_W-1:0]  report_count;
  logic [CNT_W-1:0]  first_report_cyc;
  logic [CNT_W-1:0]  cyc_count;

  modport master (
    output run, symbols, cfg_we, cfg_sel, cfg_idx, cfg_data,
    input  cfg_err, report, any_report, report_sticky,
           report_count, first_report_cyc, cyc_count
  );

  modport slave (
    input  run, symbols, cfg_we, cfg_sel, cfg_idx, cfg_data,
    output cfg_err, report, any_report, report_sticky,
           report_count, first_report_cyc, cyc_count
  );
endinterface

// File: rtl/ltl_ste_range_match.sv
// Interval store and symbol match for one STE: match when any valid interval has lo<=sym<=hi.
// Ports: clk/reset; i_we/i_k/i_data write interval i_k; i_sym symbol in; o_match combinational out.
// Writes land on the next edge; no flow control, the parent only writes while the trace is stalled.
module ltl_ste_range_match
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int N_INTV = 4,
  parameter int KW     = (N_INTV > 1) ? $clog2(N_INTV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [KW-1:0]    i_k,
  input  logic [2*SYM_W:0] i_data,
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_match
);

  // Each entry is {valid, hi, lo}, same layout as the cfg payload.
  logic [2*SYM_W:0] r_intv [N_INTV];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_INTV; k++) r_intv[k] <= '0;
    end else if (i_we) begin
      for (int k = 0; k < N_INTV; k++)
        if (i_k == KW'(k)) r_intv[k] <= i_data;
    end
  end

  // lo > hi can never satisfy both bounds, so empty intervals need no special case.
  always_comb begin
    o_match = 1'b0;
    for (int k = 0; k < N_INTV; k++) begin
      if (r_intv[k][2*SYM_W] &&
          (i_sym >= r_intv[k][SYM_W-1:0]) &&
          (i_sym <= r_intv[k][2*SYM_W-1:SYM_W]))
        o_match = 1'b1;
    end
  end

endmodule

// File: rtl/ltl_nfa_monitor_prog.sv
// Run-time programmable NFA monitor: N_STE STEs consume one trace symbol per run cycle, with report aggregation.
// Ports: clk, reset (sync, active high), bus (slave modport: trace in, cfg write port, reports/counters out).
// Symbol at t (run=1) shows in report at t+1; config only accepted while run=0, else cfg_err pulses at t+1.
module ltl_nfa_monitor_prog
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W  = SYM_W_DEF,
  parameter int N_STE  = 16,
  parameter int N_INTV = 4,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N_STE * N_INTV),
  parameter int CFG_W  = cfg_w(SYM_W, N_STE)
) (
  input  logic                  clk,
  input  logic                  reset,
  ltl_nfa_monitor_prog_if.slave bus
);

  localparam int KW = (N_INTV > 1) ? $clog2(N_INTV) : 1;

  logic [N_STE-1:0] r_active;
  logic [N_STE-1:0] r_edge [N_STE];
  ste_attr_t        r_attr [N_STE];
  logic             r_sod_arm;
  logic             r_sticky;
  logic             r_cfg_err;
  logic [CNT_W-1:0] r_report_count;
  logic [CNT_W-1:0] r_first_cyc;
  logic [CNT_W-1:0] r_cyc_count;

  logic [CFG_W-1:0] w_cfg_data;
  logic [IDX_W-1:0] w_intv_ste;
  logic [KW-1:0]    w_intv_k;
  logic             w_idx_ok;
  logic             w_cfg_ok;
  logic             w_cfg_bad;
  logic             w_sod;
  logic [N_STE-1:0] w_match;
  logic [N_STE-1:0] w_next_active;
  logic [N_STE-1:0] w_rep_en;
  logic [N_STE-1:0] w_start_all;
  logic [N_STE-1:0] w_start_sod;
  logic             w_next_any;

  // ---------------- config decode ----------------
  assign w_cfg_data = bus.cfg_data;
  assign w_intv_ste = bus.cfg_idx / IDX_W'(N_INTV);
  assign w_intv_k   = KW'(bus.cfg_idx % IDX_W'(N_INTV));

  // One extra bit on the compare so N_STE*N_INTV == 2**IDX_W is representable.
  always_comb begin
    w_idx_ok = 1'b1;
    case (bus.cfg_sel)
      CFG_INTV: w_idx_ok = ({1'b0, bus.cfg_idx} < (IDX_W+1)'(N_STE * N_INTV));
      CFG_EDGE,
      CFG_ATTR: w_idx_ok = ({1'b0, bus.cfg_idx} < (IDX_W+1)'(N_STE));
      default:  w_idx_ok = 1'b1;
    endcase
  end

  assign w_cfg_ok  = bus.cfg_we & ~bus.run & w_idx_ok;
  assign w_cfg_bad = bus.cfg_we & (bus.run | ~w_idx_ok);

  // ---------------- STE interval matchers ----------------
  for (genvar gi = 0; gi < N_STE; gi++) begin : g_ste
    logic w_we;
    assign w_we = w_cfg_ok & (bus.cfg_sel == CFG_INTV) & (w_intv_ste == IDX_W'(gi));

    ltl_ste_range_match #(
      .SYM_W  (SYM_W),
      .N_INTV (N_INTV)
    ) u_match (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_we),
      .i_k     (w_intv_k),
      .i_data  (w_cfg_data[2*SYM_W:0]),
      .i_sym   (bus.symbols),
      .o_match (w_match[gi])
    );
  end

  // ---------------- transition ----------------
  always_comb begin
    for (int i = 0; i < N_STE; i++) begin
      w_rep_en[i]    = r_attr[i].report_en;
      w_start_all[i] = r_attr[i].start_all;
      w_start_sod[i] = r_attr[i].start_sod;
    end
  end

  assign w_sod = r_sod_arm & bus.run;

  // r_edge[i] bit j set means STE j feeds STE i.
  always_comb begin
    w_next_active = '0;
    for (int i = 0; i < N_STE; i++) begin
      w_next_active[i] = w_match[i] & ((|(r_active & r_edge[i])) |
                                       (w_start_sod[i] & w_sod) |
                                       w_start_all[i]);
    end
  end

  // Report aggregation is evaluated on the state being loaded, so the counters and
  // sticky flag move in the same cycle that report first shows the new state.
  assign w_next_any = |(w_next_active & w_rep_en);

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active       <= '0;
      r_sod_arm      <= 1'b1;
      r_sticky       <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_report_count <= '0;
      r_first_cyc    <= '0;
      r_cyc_count    <= '0;
      for (int i = 0; i < N_STE; i++) begin
        r_edge[i] <= '0;
        r_attr[i] <= '0;
      end
    end else begin
      r_cfg_err <= w_cfg_bad;
      // An accepted write implies run=0, so it never competes with a trace step.
      if (w_cfg_ok) begin
        case (bus.cfg_sel)
          CFG_EDGE: begin
            for (int i = 0; i < N_STE; i++)
              if (bus.cfg_idx == IDX_W'(i)) r_edge[i] <= w_cfg_data[N_STE-1:0];
          end
          CFG_ATTR: begin
            for (int i = 0; i < N_STE; i++)
              if (bus.cfg_idx == IDX_W'(i)) r_attr[i] <= ste_attr_t'(w_cfg_data[2:0]);
          end
          CFG_CLR: begin
            r_active       <= '0;
            r_sticky       <= 1'b0;
            r_report_count <= '0;
            r_first_cyc    <= '0;
            r_cyc_count    <= '0;
            r_sod_arm      <= 1'b1;
          end
          default: ;
        endcase
      end else if (bus.run) begin
        r_active  <= w_next_active;
        r_sod_arm <= 1'b0;
        if (r_cyc_count != '1) r_cyc_count <= r_cyc_count + 1'b1;
        if (w_next_any) begin
          r_sticky <= 1'b1;
          if (r_report_count != '1) r_report_count <= r_report_count + 1'b1;
          // Timestamp is the run-cycle index of the symbol that caused the report.
          if (!r_sticky) r_first_cyc <= r_cyc_count;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.report           = r_active & w_rep_en;
  assign bus.any_report       = |(r_active & w_rep_en);
  assign bus.report_sticky    = r_sticky;
  assign bus.report_count     = r_report_count;
  assign bus.first_report_cyc = r_first_cyc;
  assign bus.cyc_count        = r_cyc_count;
  assign bus.cfg_err          = r_cfg_err;

endmodule

// File: tb/tb_ltl_nfa_monitor_prog.sv
// Bench for ltl_nfa_monitor_prog: two instances (CNT_W=16 and CNT_W=4) share one stimulus stream.
// A set-level reference model (interval lists, predecessor sets, unbounded counters) predicts every output.
// Directed program scenarios first, then randomized config/trace traffic.
module tb_ltl_nfa_monitor_prog;
  import ltl_mon_pkg::*;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ltl_nfa_monitor_prog_if #(.SYM_W(8), .N_STE(16), .N_INTV(4), .CNT_W(16)) if0 ();
  ltl_nfa_monitor_prog_if #(.SYM_W(8), .N_STE(16), .N_INTV(4), .CNT_W(4))  if1 ();

  assign if1.run      = if0.run;
  assign if1.symbols  = if0.symbols;
  assign if1.cfg_we   = if0.cfg_we;
  assign if1.cfg_sel  = if0.cfg_sel;
  assign if1.cfg_idx  = if0.cfg_idx;
  assign if1.cfg_data = if0.cfg_data;

  ltl_nfa_monitor_prog #(.SYM_W(8), .N_STE(16), .N_INTV(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(if0.slave));
  ltl_nfa_monitor_prog #(.SYM_W(8), .N_STE(16), .N_INTV(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(if1.slave));

  // ---------------- reference model ----------------
  bit [7:0]  m_lo [16][4];
  bit [7:0]  m_hi [16][4];
  bit        m_v  [16][4];
  bit [15:0] m_pred [16];
  ste_attr_t m_attr [16];
  bit        m_act [16];
  bit        m_sod_arm, m_sticky, m_err;
  int        m_cyc, m_rep, m_first;

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_act[i] = 1'b0;
    m_sticky = 0; m_rep = 0; m_first = 0; m_cyc = 0; m_sod_arm = 1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin m_lo[i][k] = 0; m_hi[i][k] = 0; m_v[i][k] = 0; end
      m_pred[i] = '0;
      m_attr[i] = '0;
    end
    m_err = 0;
    m_clear();
  endfunction

  function automatic void model_step(input bit run, input logic [7:0] sym, input bit we,
                                     input int sel, input int idx, input logic [16:0] data);
    bit ok, mt, pre, hit;
    bit nxt [16];
    intv_t t;
    case (sel)
      0:       ok = (idx < 64);
      1, 2:    ok = (idx < 16);
      default: ok = 1;
    endcase
    m_err = we && (run || !ok);
    if (we && !run && ok) begin
      case (sel)
        0: begin
          t = intv_t'(data);
          m_v[idx/4][idx%4] = t.valid; m_hi[idx/4][idx%4] = t.hi; m_lo[idx/4][idx%4] = t.lo;
        end
        1: m_pred[idx] = data[15:0];
        2: m_attr[idx] = ste_attr_t'(data[2:0]);
        default: m_clear();
      endcase
    end
    if (run) begin
      for (int i = 0; i < 16; i++) begin
        mt = 0; pre = 0;
        for (int k = 0; k < 4; k++)
          if (m_v[i][k] && sym >= m_lo[i][k] && sym <= m_hi[i][k]) mt = 1;
        for (int j = 0; j < 16; j++)
          if (m_act[j] && m_pred[i][j]) pre = 1;
        nxt[i] = mt && (pre || (m_attr[i].start_sod && m_sod_arm) || m_attr[i].start_all);
      end
      hit = 0;
      for (int i = 0; i < 16; i++) if (nxt[i] && m_attr[i].report_en) hit = 1;
      if (hit) begin
        if (!m_sticky) m_first = m_cyc;
        m_sticky = 1;
        m_rep++;
      end
      m_cyc++;
      m_sod_arm = 0;
      m_act = nxt;
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] exp_report();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = m_act[i] & m_attr[i].report_en;
    return r;
  endfunction

  function automatic logic [16:0] iv(input bit v, input int lo, input int hi);
    intv_t t;
    t.valid = v; t.lo = lo[7:0]; t.hi = hi[7:0];
    return t;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] er;
    er = exp_report();
    chk("report",        32'(if0.report),           32'(er));
    chk("report_s",      32'(if1.report),           32'(er));
    chk("any_report",    32'(if0.any_report),       32'(|er));
    chk("sticky",        32'(if0.report_sticky),    32'(m_sticky));
    chk("sticky_s",      32'(if1.report_sticky),    32'(m_sticky));
    chk("report_count",  32'(if0.report_count),     sat(m_rep, 16));
    chk("report_count4", 32'(if1.report_count),     sat(m_rep, 4));
    chk("first_cyc",     32'(if0.first_report_cyc), sat(m_first, 16));
    chk("first_cyc4",    32'(if1.first_report_cyc), sat(m_first, 4));
    chk("cyc_count",     32'(if0.cyc_count),        sat(m_cyc, 16));
    chk("cyc_count4",    32'(if1.cyc_count),        sat(m_cyc, 4));
    chk("cfg_err",       32'(if0.cfg_err),          32'(m_err));
    chk("cfg_err_s",     32'(if1.cfg_err),          32'(m_err));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check #1 later.
  task automatic step(input bit run, input logic [7:0] sym, input bit we,
                      input int sel, input int idx, input logic [16:0] data);
    if0.run      = run;
    if0.symbols  = sym;
    if0.cfg_we   = we;
    if0.cfg_sel  = cfg_sel_e'(sel[1:0]);
    if0.cfg_idx  = idx[5:0];
    if0.cfg_data = data;
    @(posedge clk);
    model_step(run, sym, we, sel, int'(idx[5:0]), data);
    #1;
    check_all();
  endtask

  task automatic cfg(input int sel, input int idx, input logic [16:0] data);
    step(1'b0, 8'($urandom_range(0, 255)), 1'b1, sel, idx, data);
  endtask

  task automatic feed(input logic [7:0] sym);
    step(1'b1, sym, 1'b0, 0, 0, 17'h0);
  endtask

  task automatic soft_clear();
    cfg(3, 0, 17'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, sel, idx;
    bit run;
    logic [16:0] d;

    // ---- reset (a config write during reset must be dropped) ----
    reset = 1'b1;
    if0.run = 0; if0.symbols = 0; if0.cfg_we = 1; if0.cfg_sel = CFG_ATTR;
    if0.cfg_idx = 6'd2; if0.cfg_data = 17'h7;
    repeat (3) @(posedge clk);
    #1;
    if0.cfg_we = 0;
    m_reset();
    check_all();
    chk("reset_cyc", 32'(if0.cyc_count), 32'd0);
    reset = 1'b0;

    // ---- chain: STE0 [0,7] start_sod -> STE1 [8,15] report ----
    cfg(0, 0, iv(1, 0, 7));
    cfg(0, 4, iv(1, 8, 15));
    cfg(1, 1, 17'h1);
    cfg(2, 0, 17'b001);
    cfg(2, 1, 17'b100);
    feed(8'd3);
    chk("chain_no_early", 32'(if0.report), 32'h0);
    feed(8'd9);
    chk("chain_report", 32'(if0.report), 32'h2);
    chk("chain_count", 32'(if0.report_count), 32'd1);
    chk("chain_first", 32'(if0.first_report_cyc), 32'd1);
    step(1'b0, 8'd200, 1'b0, 0, 0, 17'h0);

    // ---- start_sod misses STE0 on a non-matching first symbol ----
    soft_clear();
    feed(8'd20); feed(8'd3); feed(8'd9);
    chk("sod_missed", 32'(if0.any_report), 32'd0);
    soft_clear();
    cfg(2, 0, 17'b011);
    feed(8'd20); feed(8'd3); feed(8'd9);
    chk("start_all_report", 32'(if0.report), 32'h2);

    // ---- self-loop on STE0 ----
    soft_clear();
    cfg(2, 1, 17'b000);
    cfg(1, 1, 17'h0);
    cfg(0, 0, iv(1, 0, 63));
    cfg(1, 0, 17'h1);
    cfg(2, 0, 17'b101);
    feed(8'd5); chk("loop_1", 32'(if0.report), 32'h1);
    feed(8'd6); chk("loop_2", 32'(if0.report), 32'h1);
    feed(8'd7); chk("loop_3", 32'(if0.report), 32'h1);
    feed(8'd200);
    chk("loop_drop", 32'(if0.report), 32'h0);
    chk("loop_count", 32'(if0.report_count), 32'd3);
    chk("loop_sticky", 32'(if0.report_sticky), 32'd1);

    // ---- config guard ----
    step(1'b1, 8'd10, 1'b1, 1, 0, 17'h0);
    chk("guard_run_err", 32'(if0.cfg_err), 32'd1);
    soft_clear();
    chk("guard_err_pulse", 32'(if0.cfg_err), 32'd0);
    chk("clear_count", 32'(if0.report_count), 32'd0);
    chk("clear_sticky", 32'(if0.report_sticky), 32'd0);
    chk("clear_cyc", 32'(if0.cyc_count), 32'd0);
    feed(8'd5); feed(8'd6);
    chk("guard_edge_kept", 32'(if0.report), 32'h1);
    cfg(2, 16, 17'b111);
    chk("guard_idx_err", 32'(if0.cfg_err), 32'd1);
    cfg(0, 63, 17'h0);
    chk("guard_idx_ok", 32'(if0.cfg_err), 32'd0);

    // ---- soft clear mid-run re-arms start_of_data ----
    soft_clear();
    chk("clear_active", 32'(if0.report), 32'h0);
    feed(8'd5);
    chk("clear_sod", 32'(if0.report), 32'h1);
    chk("clear_first", 32'(if0.first_report_cyc), 32'd0);

    // ---- saturation ----
    soft_clear();
    for (int n = 0; n < 20; n++) feed(8'($urandom_range(0, 63)));
    chk("sat_count16", 32'(if0.report_count), 32'd20);
    chk("sat_count4", 32'(if1.report_count), 32'd15);
    chk("sat_cyc4", 32'(if1.cyc_count), 32'd15);

    // ---- randomized programs and traffic ----
    soft_clear();
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 200);
        cfg(0, i*4 + k, iv(1, r, r + $urandom_range(0, 80)));
      end
      cfg(1, i, 17'($urandom & $urandom & 32'hFFFF));
      cfg(2, i, 17'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        sel = $urandom_range(0, 2);
        idx = $urandom_range(0, 63);
        run = ($urandom_range(0, 3) == 0);
        d   = 17'($urandom);
        step(run, 8'($urandom_range(0, 255)), 1'b1, sel, idx, d);
      end else if (r < 11) begin
        run = ($urandom_range(0, 3) == 0);
        step(run, 8'($urandom_range(0, 255)), 1'b1, 3, 0, 17'h0);
      end else begin
        run = ($urandom_range(0, 4) != 0);
        step(run, 8'($urandom_range(0, 255)), 1'b0, 0, 0, 17'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
